// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Requests are accepted on req && gnt; responses return in request order.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (output req, output addr, input gnt, input rsp_valid, input rsp_data);
    modport slave  (input req, input addr, output gnt, output rsp_valid, output rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, predictor-steered next-PC, pipelined imem
// handshake with in-flight tag FIFO, stale-response squashing and a fetch queue for decode.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter int unsigned     MAX_OUT  = 4,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    imem,
    input  logic            bp_taken,
    input  logic [XLEN-1:0] bp_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken
);
    // One spare bit so occ + outstanding (at most 2*FQ_DEPTH) never overflows.
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1) + 1;
    localparam int unsigned QW    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned TW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] FQ_DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C  = CNT_W'(MAX_OUT);
    localparam logic [TW-1:0]    TAG_LAST   = TW'(MAX_OUT - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred;
    } tag_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred;
    } fq_entry_t;

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] occ, outstanding, drop;
    logic [CNT_W-1:0] occ_next, out_next;

    tag_t             tag_mem [MAX_OUT];
    logic [TW-1:0]    tag_wr, tag_rd;
    fq_entry_t        fq_mem [FQ_DEPTH];
    logic [QW-1:0]    fq_wr, fq_rd;

    logic             issue, rsp_take, rsp_keep, fq_pop;
    tag_t             rsp_tag;
    fq_entry_t        head;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + TW'(1);
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        imem.req  = rst && !redirect_valid
                    && ((occ + outstanding) < FQ_DEPTH_C)
                    && (outstanding < MAX_OUT_C);
        imem.addr = pc;
        issue     = imem.req && imem.gnt;

        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_take  = imem.rsp_valid && (outstanding != '0);
        rsp_tag   = tag_mem[tag_rd];
        rsp_keep  = rsp_take && (drop == '0) && !redirect_valid;

        head          = fq_mem[fq_rd];
        id_valid      = (occ != '0);
        id_inst       = id_valid ? head.inst : NOP_INST;
        id_pc         = id_valid ? head.pc   : '0;
        id_pred_taken = id_valid && head.pred;
        fq_pop        = id_valid && id_ready && !redirect_valid;

        occ_next = occ;
        if (rsp_keep && !fq_pop)      occ_next = occ + ONE;
        else if (!rsp_keep && fq_pop) occ_next = occ - ONE;

        out_next = outstanding;
        if (issue && !rsp_take)      out_next = outstanding + ONE;
        else if (!issue && rsp_take) out_next = outstanding - ONE;
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            occ         <= '0;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fq_wr       <= '0;
            fq_rd       <= '0;
        end else begin
            outstanding <= out_next;
            if (issue) begin
                pc     <= bp_taken ? bp_target : pc + XLEN'(4);
                tag_wr <= tag_inc(tag_wr);
            end
            if (rsp_take) tag_rd <= tag_inc(tag_rd);

            if (redirect_valid) begin
                // Everything still in flight belongs to the squashed path.
                pc    <= redirect_pc;
                occ   <= '0;
                fq_wr <= '0;
                fq_rd <= '0;
                drop  <= out_next;
            end else begin
                occ <= occ_next;
                if (rsp_take && (drop != '0)) drop <= drop - ONE;
                if (rsp_keep) fq_wr <= fq_wr + QW'(1);
                if (fq_pop)   fq_rd <= fq_rd + QW'(1);
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers and counts make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (issue)    tag_mem[tag_wr] <= '{pc: pc, pred: bp_taken};
        if (rsp_keep) fq_mem[fq_wr]   <= '{inst: imem.rsp_data, pc: rsp_tag.pc, pred: rsp_tag.pred};
    end

    a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst)
        !(imem.rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized imem/decode/predictor/redirect traffic
// scored against a transaction-level model of the fetch stream, plus directed scenarios.
module tb_fetch_unit;
    localparam int unsigned FQ_DEPTH = 4;
    localparam int unsigned MAX_OUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_pred_taken;

    fetch_unit_if #(.XLEN(32)) imem_bus ();

    fetch_unit #(
        .XLEN(32), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUT(MAX_OUT), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst(rst), .imem(imem_bus),
        .bp_taken(bp_taken), .bp_target(bp_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst),
        .id_pc(id_pc), .id_pred_taken(id_pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        int unsigned epoch;
        int unsigned cyc;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } dec_t;

    // Reference model: requests in flight (also the memory's pending list) and the
    // instructions decode should see, in order.
    req_t        pend_q[$];
    dec_t        exp_q[$];
    dec_t        obs_log[$];
    logic [31:0] m_pc;
    int unsigned epoch = 0;
    int unsigned cyc   = 0;
    int unsigned n_gnt = 0;
    int unsigned n_dec = 0;

    int vectors     = 0;
    int miscompares = 0;

    int unsigned p_gnt, p_rsp, p_ready, p_redirect, p_bp;
    logic        bp_match_en = 1'b0;
    logic [31:0] bp_match_addr, bp_match_target;
    logic        force_redirect = 1'b0;
    logic [31:0] force_pc;

    function automatic logic rnd(input int unsigned pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic drive_idle();
        imem_bus.gnt       = 1'b0;
        imem_bus.rsp_valid = 1'b0;
        imem_bus.rsp_data  = '0;
        bp_taken           = 1'b0;
        bp_target          = '0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        id_ready           = 1'b0;
    endtask

    task automatic model_clear();
        pend_q.delete();
        exp_q.delete();
        m_pc  = RESET_PC;
        epoch = epoch + 1;
    endtask

    task automatic knobs(input int unsigned g, input int unsigned r, input int unsigned rdy,
                         input int unsigned redir, input int unsigned bp);
        p_gnt = g; p_rsp = r; p_ready = rdy; p_redirect = redir; p_bp = bp;
    endtask

    // Entered and left at posedge+1: applies one cycle of stimulus, checks at negedge.
    task automatic cycle();
        logic        rsp, exp_req, hs, acc;
        logic [31:0] rdata;
        req_t        r;
        dec_t        d;
        cyc = cyc + 1;
        rsp   = (pend_q.size() > 0) && (pend_q[0].cyc < cyc) && rnd(p_rsp);
        rdata = $urandom;
        imem_bus.gnt       = rnd(p_gnt);
        imem_bus.rsp_valid = rsp;
        imem_bus.rsp_data  = rdata;
        id_ready           = rnd(p_ready);
        redirect_valid     = force_redirect || rnd(p_redirect);
        redirect_pc        = force_redirect ? force_pc : $urandom;
        force_redirect     = 1'b0;
        if (bp_match_en) begin
            bp_taken  = (m_pc == bp_match_addr);
            bp_target = bp_match_target;
        end else begin
            bp_taken  = rnd(p_bp);
            bp_target = $urandom & 32'hFFFF_FFFC;
        end

        @(negedge clk);
        exp_req = !redirect_valid && (exp_q.size() + pend_q.size() < FQ_DEPTH)
                  && (pend_q.size() < MAX_OUT);
        vectors++;
        if (imem_bus.req !== exp_req) begin
            miscompares++;
            $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_bus.req, exp_req);
        end
        vectors++;
        if (imem_bus.addr !== m_pc) begin
            miscompares++;
            $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_bus.addr, m_pc);
        end
        vectors++;
        if (id_valid !== (exp_q.size() != 0)) begin
            miscompares++;
            $display("FAIL id_valid cyc=%0d got=%b want=%b", cyc, id_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            d = exp_q[0];
            vectors++;
            if ({id_pc, id_inst, id_pred_taken} !== {d.pc, d.inst, d.pred}) begin
                miscompares++;
                $display("FAIL id_head cyc=%0d got pc=%h inst=%h pred=%b want pc=%h inst=%h pred=%b",
                         cyc, id_pc, id_inst, id_pred_taken, d.pc, d.inst, d.pred);
            end
        end else begin
            vectors++;
            if ({id_pc, id_inst, id_pred_taken} !== {32'h0, NOP, 1'b0}) begin
                miscompares++;
                $display("FAIL id_bubble cyc=%0d got pc=%h inst=%h pred=%b want pc=0 inst=%h pred=0",
                         cyc, id_pc, id_inst, id_pred_taken, NOP);
            end
        end

        hs  = exp_req && imem_bus.gnt;
        acc = (exp_q.size() != 0) && id_ready;
        if (acc) begin
            void'(exp_q.pop_front());
            obs_log.push_back('{id_pc, id_inst, id_pred_taken});
            n_dec++;
        end
        if (rsp) begin
            r = pend_q.pop_front();
            if (r.epoch == epoch && !redirect_valid) exp_q.push_back('{r.pc, rdata, r.pred});
        end
        if (hs) begin
            pend_q.push_back('{m_pc, bp_taken, epoch, cyc});
            n_gnt++;
            m_pc = bp_taken ? bp_target : m_pc + 32'd4;
        end
        if (redirect_valid) begin
            epoch = epoch + 1;
            exp_q.delete();
            m_pc = redirect_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        model_clear();
        obs_log.delete();
        bp_match_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        vectors++;
        if (imem_bus.req !== 1'b0 || imem_bus.addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_imem got req=%b addr=%h want req=0 addr=%h",
                     imem_bus.req, imem_bus.addr, RESET_PC);
        end
        vectors++;
        if ({id_valid, id_pc, id_inst, id_pred_taken} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_id got v=%b pc=%h inst=%h pred=%b want v=0 pc=0 inst=%h pred=0",
                     id_valid, id_pc, id_inst, id_pred_taken, NOP);
        end
        do_reset();
    endtask

    task automatic test_in_order();
        do_reset();
        knobs(100, 100, 100, 0, 0);
        run(20);
        vectors++;
        if (obs_log.size() < 10) begin
            miscompares++;
            $display("FAIL in_order_count got=%0d want>=10", obs_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (obs_log[i].pc !== RESET_PC + 32'(4 * i)) begin
                    miscompares++;
                    $display("FAIL in_order_pc idx=%0d got=%h want=%h", i, obs_log[i].pc,
                             RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_stall();
        int unsigned g0;
        do_reset();
        knobs(100, 100, 0, 0, 0);
        g0 = n_gnt;
        run(10);
        vectors++;
        if (n_gnt - g0 != FQ_DEPTH) begin
            miscompares++;
            $display("FAIL stall_requests got=%0d want=%0d", n_gnt - g0, FQ_DEPTH);
        end
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL stall_head got v=%b pc=%h want v=1 pc=%h", id_valid, id_pc, RESET_PC);
        end
        knobs(100, 100, 100, 0, 0);
        run(20);
        vectors++;
        if (obs_log.size() < 8) begin
            miscompares++;
            $display("FAIL stall_resume_count got=%0d want>=8", obs_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (obs_log[i].pc !== RESET_PC + 32'(4 * i)) begin
                    miscompares++;
                    $display("FAIL stall_resume_pc idx=%0d got=%h want=%h", i, obs_log[i].pc,
                             RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_predict();
        logic [31:0] pcs [5];
        logic        prd [5];
        pcs = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
        prd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        knobs(100, 100, 100, 0, 0);
        bp_match_en     = 1'b1;
        bp_match_addr   = 32'h8;
        bp_match_target = 32'h40;
        run(15);
        bp_match_en = 1'b0;
        vectors++;
        if (obs_log.size() < 5) begin
            miscompares++;
            $display("FAIL predict_count got=%0d want>=5", obs_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (obs_log[i].pc !== pcs[i] || obs_log[i].pred !== prd[i]) begin
                    miscompares++;
                    $display("FAIL predict_stream idx=%0d got pc=%h pred=%b want pc=%h pred=%b",
                             i, obs_log[i].pc, obs_log[i].pred, pcs[i], prd[i]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int unsigned g0;
        do_reset();
        knobs(100, 0, 100, 0, 0);
        g0 = n_gnt;
        run(3);
        vectors++;
        if (n_gnt - g0 != 3 || pend_q.size() != 3) begin
            miscompares++;
            $display("FAIL redirect_setup got grants=%0d pending=%0d want 3 and 3",
                     n_gnt - g0, pend_q.size());
        end
        knobs(0, 0, 100, 0, 0);
        force_redirect = 1'b1;
        force_pc       = 32'h100;
        cycle();
        knobs(100, 100, 100, 0, 0);
        run(20);
        vectors++;
        if (obs_log.size() == 0 || obs_log[0].pc !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_first got n=%0d pc=%h want pc=00000100", obs_log.size(),
                     (obs_log.size() != 0) ? obs_log[0].pc : 32'hx);
        end
    endtask

    task automatic test_gnt_low();
        do_reset();
        knobs(100, 100, 100, 0, 0);
        run(3);
        knobs(0, 100, 100, 0, 0);
        run(5);
        vectors++;
        if (imem_bus.addr !== RESET_PC + 32'd12) begin
            miscompares++;
            $display("FAIL gnt_low_hold got=%h want=%h", imem_bus.addr, RESET_PC + 32'd12);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [4];
        pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        do_reset();
        knobs(100, 100, 100, 0, 0);
        force_redirect = 1'b1;
        force_pc       = 32'hFFFF_FFF8;
        run(12);
        vectors++;
        if (obs_log.size() < 4) begin
            miscompares++;
            $display("FAIL wrap_count got=%0d want>=4", obs_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (obs_log[i].pc !== pcs[i]) begin
                    miscompares++;
                    $display("FAIL wrap_pc idx=%0d got=%h want=%h", i, obs_log[i].pc, pcs[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        knobs(100, 50, 70, 0, 0);
        run(6);
        rst = 1'b0;
        #1;
        vectors++;
        if (imem_bus.req !== 1'b0 || imem_bus.addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL midreset_imem got req=%b addr=%h want req=0 addr=%h",
                     imem_bus.req, imem_bus.addr, RESET_PC);
        end
        vectors++;
        if ({id_valid, id_pc, id_inst, id_pred_taken} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_id got v=%b pc=%h inst=%h pred=%b want v=0 pc=0 inst=%h pred=0",
                     id_valid, id_pc, id_inst, id_pred_taken, NOP);
        end
        do_reset();
    endtask

    task automatic test_random();
        int unsigned d0;
        do_reset();
        knobs(70, 60, 70, 3, 20);
        d0 = n_dec;
        run(3000);
        vectors++;
        if (n_dec - d0 < 100) begin
            miscompares++;
            $display("FAIL random_progress got=%0d want>=100", n_dec - d0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        knobs(0, 0, 0, 0, 0);
        test_reset();
        test_in_order();
        test_stall();
        test_predict();
        test_redirect();
        test_gnt_low();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
